// File: rtl/dilithium_pkg.sv
// Shared ML-DSA constants: modulus, polynomial shape, challenge code points and
// the unpacker state encoding. SampleInBall packs with the same code constants.
package dilithium_pkg;
  localparam int N           = 256;
  localparam int TAU         = 60;
  localparam int COEFF_WIDTH = 2;
  localparam int Q           = 8380417;
  localparam int COEFF_BITS  = 23;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/challenge_coeff_decode.sv
// One lane of challenge decode: 2-bit code to a coefficient in [0, Q).
// Code 2'b10 is not produced by SampleInBall; it decodes to 0 and flags illegal.
module challenge_coeff_decode
  import dilithium_pkg::*;
(
  input  logic [1:0]            code,
  output logic [COEFF_BITS-1:0] coeff,
  output logic                  nonzero,
  output logic                  illegal
);
  always_comb begin
    coeff   = '0;
    nonzero = 1'b0;
    illegal = 1'b0;
    case (code)
      CODE_ZERO: ;
      CODE_POS: begin
        coeff   = COEFF_BITS'(1);
        nonzero = 1'b1;
      end
      CODE_NEG: begin
        coeff   = COEFF_BITS'(Q - 1);
        nonzero = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/challenge_unpack.sv
// Streams the packed challenge polynomial as LANES decoded coefficients per beat,
// accumulating Hamming weight and illegal-code status for a final err verdict.
module challenge_unpack
  import dilithium_pkg::*;
#(
  parameter int N             = dilithium_pkg::N,
  parameter int TAU           = dilithium_pkg::TAU,
  parameter int COEFF_WIDTH   = dilithium_pkg::COEFF_WIDTH,
  parameter int Q             = dilithium_pkg::Q,
  parameter int DATA_OUT_BITS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [COEFF_WIDTH*N-1:0]   poly_pack,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_OUT_BITS-1:0]   out_data,
  output logic                       out_last,
  output logic                       done,
  output logic [8:0]                 weight,
  output logic                       err
);
  localparam int LANES = DATA_OUT_BITS / 32;
  localparam int BEATS = N / LANES;
  localparam int CW    = $clog2(BEATS);
  localparam int PW    = COEFF_WIDTH * N;
  localparam int SH    = COEFF_WIDTH * LANES;

  state_t                              state, state_nxt;
  logic [PW-1:0]                       shreg;
  logic [CW-1:0]                       beat_cnt;
  logic [8:0]                          weight_q;
  logic                                illegal_q;
  logic                                err_q;

  logic [LANES-1:0][COEFF_BITS-1:0]    lane_coeff;
  logic [LANES-1:0]                    lane_nz;
  logic [LANES-1:0]                    lane_ill;
  logic [8:0]                          nz_cnt;
  logic [8:0]                          weight_nxt;
  logic                                ill_nxt;
  logic                                hs;
  logic                                beat_last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    challenge_coeff_decode u_dec (
      .code    (shreg[COEFF_WIDTH*g +: 2]),
      .coeff   (lane_coeff[g]),
      .nonzero (lane_nz[g]),
      .illegal (lane_ill[g])
    );
  end

  always_comb begin
    nz_cnt = '0;
    for (int k = 0; k < LANES; k++) nz_cnt = nz_cnt + 9'(lane_nz[k]);
  end

  assign weight_nxt = weight_q + nz_cnt;
  assign ill_nxt    = illegal_q | (|lane_ill);
  assign out_valid  = (state == ST_STREAM);
  assign beat_last  = (beat_cnt == CW'(BEATS - 1));
  assign hs         = out_valid && out_ready;
  assign out_last   = out_valid && beat_last;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign weight     = weight_q;
  assign err        = err_q;

  // Lanes are gated so the bus reads zero whenever no beat is offered.
  always_comb begin
    out_data = '0;
    if (out_valid)
      for (int k = 0; k < LANES; k++)
        out_data[32*k +: 32] = {{(32-COEFF_BITS){1'b0}}, lane_coeff[k]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: if (hs && beat_last) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      beat_cnt  <= '0;
      weight_q  <= '0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (start) begin
          shreg     <= poly_pack;
          beat_cnt  <= '0;
          weight_q  <= '0;
          illegal_q <= 1'b0;
          err_q     <= 1'b0;
        end
        ST_STREAM: if (hs) begin
          shreg     <= shreg >> SH;
          beat_cnt  <= beat_cnt + 1'b1;
          weight_q  <= weight_nxt;
          illegal_q <= ill_nxt;
          // Verdict is formed from the post-beat totals so it is ready in DONE.
          if (beat_last) err_q <= ill_nxt | (weight_nxt != 9'(TAU));
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_challenge_unpack.sv
// Directed bench for challenge_unpack: full streams with fixed vectors, stalls,
// illegal code, start-ignore cases and mid-stream reset.
module tb_challenge_unpack;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [511:0] poly_pack;
  logic         busy, out_valid, out_ready, out_last, done, err;
  logic [63:0]  out_data;
  logic [8:0]   weight;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  challenge_unpack dut (
    .clk(clk), .rst_n(rst_n), .start(start), .poly_pack(poly_pack),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done),
    .weight(weight), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input logic [511:0] v, input int b);
    logic [63:0] r;
    logic [1:0]  c;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      c = v[2*(2*b+k) +: 2];
      if (c == 2'b01)      r[32*k +: 32] = 32'h0000_0001;
      else if (c == 2'b11) r[32*k +: 32] = 32'h007F_E000;
    end
    return r;
  endfunction

  // mode 0: ready held high; mode 1: ready 1,0,0,1 with a stray start mid-stream.
  task automatic do_stream(input string nm, input logic [511:0] vec, input int mode,
                           input logic [8:0] exp_w, input logic exp_e, input bit start_at_done,
                           output logic [63:0] beat0, output logic [63:0] beat127);
    int          hs = 0;
    int          cyc = 0;
    bit          stalled = 0;
    logic [63:0] pdata;
    logic        plast;
    beat0 = '0; beat127 = '0; pdata = '0; plast = 1'b0;
    start = 1'b1; poly_pack = vec;
    @(posedge clk); #1;
    start = 1'b0; poly_pack = '1;
    while (hs < 128 && cyc < 2000) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      start = (mode == 1 && cyc == 5);
      chk({nm, " valid"}, 64'(out_valid), 64'd1);
      chk({nm, " done_low"}, 64'(done), 64'd0);
      if (stalled) begin
        chk({nm, " stall_data"}, out_data, pdata);
        chk({nm, " stall_last"}, 64'(out_last), 64'(plast));
      end
      if (out_ready) begin
        chk({nm, " data"}, out_data, exp_beat(vec, hs));
        chk({nm, " last"}, 64'(out_last), 64'(hs == 127));
        if (hs == 0)   beat0 = out_data;
        if (hs == 127) beat127 = out_data;
        hs++;
      end
      stalled = !out_ready;
      pdata = out_data; plast = out_last;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, " handshakes"}, 64'(hs), 64'd128);
    if (mode == 0) chk({nm, " cycles"}, 64'(cyc), 64'd128);
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " dvalid"}, 64'(out_valid), 64'd0);
    chk({nm, " weight"}, 64'(weight), 64'(exp_w));
    chk({nm, " err"}, 64'(err), 64'(exp_e));
    if (start_at_done) begin start = 1'b1; poly_pack = '0; end
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " idle_busy"}, 64'(busy), 64'd0);
    chk({nm, " idle_valid"}, 64'(out_valid), 64'd0);
    chk({nm, " idle_done"}, 64'(done), 64'd0);
    chk({nm, " hold_weight"}, 64'(weight), 64'(exp_w));
    chk({nm, " hold_err"}, 64'(err), 64'(exp_e));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " idle_stays"}, 64'(busy), 64'd0);
  endtask

  logic [511:0] v0, v1, v2, v3, v4;
  logic [63:0]  b0, b127;

  initial begin
    v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    for (int i = 0; i < 60; i++) v1[2*i +: 2] = 2'b01;
    v2[1:0] = 2'b11; v2[3:2] = 2'b01;
    for (int i = 2; i < 60; i++) v2[2*i +: 2] = (i % 2) ? 2'b01 : 2'b11;
    for (int i = 0; i < 60; i++) v3[8*i +: 2] = (i % 3 == 0) ? 2'b11 : 2'b01;
    v4 = v3; v4[511:510] = 2'b10;

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; poly_pack = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst valid", 64'(out_valid), 64'd0);
    chk("rst data", out_data, 64'd0);
    chk("rst last", 64'(out_last), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst weight", 64'(weight), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle ready ignored", 64'(busy), 64'd0);

    do_stream("zero", v0, 0, 9'd0, 1'b1, 0, b0, b127);
    chk("zero b0", b0, 64'd0);
    do_stream("pos60", v1, 0, 9'd60, 1'b0, 1, b0, b127);
    chk("pos60 b0", b0, 64'h00000001_00000001);
    chk("pos60 b127", b127, 64'd0);
    do_stream("mixed", v2, 0, 9'd60, 1'b0, 0, b0, b127);
    chk("mixed b0", b0, 64'h00000001_007FE000);
    do_stream("stall", v3, 1, 9'd60, 1'b0, 0, b0, b127);
    chk("stall b0", b0, 64'h007FE000);
    do_stream("illegal", v4, 0, 9'd60, 1'b1, 0, b0, b127);
    chk("illegal b127", b127, 64'd0);

    start = 1'b1; poly_pack = v1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) begin @(posedge clk); #1; end
    chk("mid busy", 64'(busy), 64'd1);
    chk("mid weight", 64'(weight), 64'd60);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst valid", 64'(out_valid), 64'd0);
    chk("mrst busy", 64'(busy), 64'd0);
    chk("mrst weight", 64'(weight), 64'd0);
    chk("mrst data", out_data, 64'd0);
    chk("mrst err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_stream("after_rst", v2, 0, 9'd60, 1'b0, 0, b0, b127);
    chk("after_rst b0", b0, 64'h00000001_007FE000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
